// File: rtl/mmio_arbiter_if.sv
// Request/response bundle shared by the MMIO arbiter, its two requesters (core, DMA)
// and the downstream peripheral bus.
interface mmio_arbiter_if;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned SIZE_W = 2;

  // core requester (MEM stage)
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [SIZE_W-1:0] core_size;
  logic              flush;
  logic              core_done;
  logic              core_stall;

  // dma requester
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [SIZE_W-1:0] dma_size;
  logic              dma_done;

  // shared response, valid while a done pulse is high
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  // peripheral bus
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [SIZE_W-1:0] bus_size;
  logic              bus_ack;
  logic              bus_err;
  logic [DATA_W-1:0] bus_rdata;

  // arbiter side: owns the peripheral bus, answers both requesters
  modport master (
    input  core_req, core_we, core_addr, core_wdata, core_size, flush,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_size,
    input  bus_ack, bus_err, bus_rdata,
    output core_done, core_stall, dma_done, rsp_rdata, rsp_err,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_size
  );

  // environment side: requesters plus the peripheral
  modport slave (
    output core_req, core_we, core_addr, core_wdata, core_size, flush,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_size,
    output bus_ack, bus_err, bus_rdata,
    input  core_done, core_stall, dma_done, rsp_rdata, rsp_err,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_size
  );
endinterface

// File: rtl/mmio_arbiter.sv
// Round-robin arbiter of core and DMA MMIO requests onto one peripheral bus.
// Define MMIO_TIMEOUT_EN to add a per-transaction bus watchdog of TIMEOUT_CYCLES cycles.
module mmio_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic           clock,
  input  logic           reset,
  mmio_arbiter_if.master mif
);
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned SIZE_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [SIZE_W-1:0] size;
  } xfer_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mmio_arbiter: TIMEOUT_CYCLES must be within 1..255");
  end

`ifdef MMIO_TIMEOUT_EN
  localparam int unsigned      CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;  // 0 core, 1 dma
  logic              owner_q, owner_d;            // owner of the transaction in flight
  logic              flushed_q, flushed_d;        // core transaction flushed while in flight
  logic              bus_req_q, bus_req_d;
  xfer_t             xfer_q, xfer_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              core_done_q, core_done_d;
  logic              dma_done_q, dma_done_d;

  xfer_t core_x, dma_x, win_x;
  logic  any_req, grant_dma, win_misaligned, finish;
  logic  core_done_c;

  function automatic logic misaligned(input logic [2:0] addr_lo, input logic [SIZE_W-1:0] size);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return addr_lo[0];
      2'd2:    return |addr_lo[1:0];
      default: return |addr_lo;
    endcase
  endfunction

  // Winner selection: a lone requester wins, a tie goes to whoever did not win last.
  always_comb begin
    core_x         = '{we: mif.core_we, addr: mif.core_addr, wdata: mif.core_wdata, size: mif.core_size};
    dma_x          = '{we: mif.dma_we, addr: mif.dma_addr, wdata: mif.dma_wdata, size: mif.dma_size};
    any_req        = mif.core_req | mif.dma_req;
    grant_dma      = mif.dma_req & (~mif.core_req | ~last_grant_q);
    win_x          = grant_dma ? dma_x : core_x;
    win_misaligned = misaligned(win_x.addr[2:0], win_x.size);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    flushed_d    = flushed_q;
    bus_req_d    = bus_req_q;
    xfer_d       = xfer_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    core_done_d  = 1'b0;
    dma_done_d   = 1'b0;
    finish       = 1'b0;
`ifdef MMIO_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d      = grant_dma;
          last_grant_d = grant_dma;
          flushed_d    = 1'b0;
          if (win_misaligned) begin
            // Rejected locally: the bus never sees a misaligned access.
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            core_done_d = ~grant_dma;
            dma_done_d  = grant_dma;
            state_d     = RESP;
          end else begin
            xfer_d    = win_x;
            bus_req_d = 1'b1;
            state_d   = BUSY;
`ifdef MMIO_TIMEOUT_EN
            cnt_d     = '0;
`endif
          end
        end
      end

      BUSY: begin
        if (mif.flush && !owner_q) flushed_d = 1'b1;
        if (mif.bus_ack) begin
          bus_req_d   = 1'b0;
          rsp_rdata_d = xfer_q.we ? '0 : mif.bus_rdata;
          rsp_err_d   = mif.bus_err;
          finish      = 1'b1;
        end
`ifdef MMIO_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          bus_req_d   = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          finish      = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
        if (finish) begin
          core_done_d = ~owner_q & ~flushed_q & ~mif.flush;
          dma_done_d  = owner_q;
          state_d     = RESP;
        end
      end

      RESP: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      flushed_q    <= 1'b0;
      bus_req_q    <= 1'b0;
      xfer_q       <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      core_done_q  <= 1'b0;
      dma_done_q   <= 1'b0;
`ifdef MMIO_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      flushed_q    <= flushed_d;
      bus_req_q    <= bus_req_d;
      xfer_q       <= xfer_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      core_done_q  <= core_done_d;
      dma_done_q   <= dma_done_d;
`ifdef MMIO_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  // A flush landing on the response cycle itself must still kill the core's done pulse.
  assign core_done_c    = core_done_q & ~mif.flush;

  assign mif.core_done  = core_done_c;
  assign mif.core_stall = mif.core_req & ~core_done_c;
  assign mif.dma_done   = dma_done_q;
  assign mif.rsp_rdata  = rsp_rdata_q;
  assign mif.rsp_err    = rsp_err_q;
  assign mif.bus_req    = bus_req_q;
  assign mif.bus_we     = xfer_q.we;
  assign mif.bus_addr   = xfer_q.addr;
  assign mif.bus_wdata  = xfer_q.wdata;
  assign mif.bus_size   = xfer_q.size;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Self-checking bench for mmio_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level reference model.
module tb_mmio_arbiter;
  localparam int unsigned TB_TIMEOUT = 4;

  logic clock;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  mmio_arbiter_if mif ();

  mmio_arbiter #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .mif   (mif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    mif.core_req = 1'b0; mif.core_we = 1'b0; mif.core_addr = '0; mif.core_wdata = '0; mif.core_size = '0;
    mif.dma_req  = 1'b0; mif.dma_we  = 1'b0; mif.dma_addr  = '0; mif.dma_wdata  = '0; mif.dma_size  = '0;
    mif.flush    = 1'b0;
    mif.bus_ack  = 1'b0; mif.bus_err = 1'b0; mif.bus_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  function automatic logic [63:0] rand_addr(input logic [1:0] size);
    logic [63:0] a = {$urandom, $urandom};
    if ($urandom_range(0, 2) != 0) a = a & ~((64'd1 << size) - 64'd1);
    return a;
  endfunction

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    tests++;
    if ({mif.bus_req, mif.bus_we, mif.bus_size, mif.core_done, mif.dma_done, mif.rsp_err, mif.core_stall} !== 8'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 00000000",
               {mif.bus_req, mif.bus_we, mif.bus_size, mif.core_done, mif.dma_done, mif.rsp_err, mif.core_stall});
    end
    tests++;
    if ({mif.bus_addr, mif.bus_wdata, mif.rsp_rdata} !== 192'd0) begin
      fails++;
      $display("FAIL reset_data: addr %h wdata %h rdata %h want all zero", mif.bus_addr, mif.bus_wdata, mif.rsp_rdata);
    end
    reset = 1'b0;
    step();
    tests++;
    if ({mif.bus_req, mif.core_done, mif.dma_done} !== 3'b000) begin
      fails++;
      $display("FAIL reset_idle: got %b want 000", {mif.bus_req, mif.core_done, mif.dma_done});
    end
  endtask

  task automatic test_core_load();
    int stall_cycles = 0;
    idle_inputs();
    step();
    mif.core_req = 1'b1; mif.core_we = 1'b0; mif.core_addr = 64'h2008; mif.core_size = 2'd3;
    #1;
    if (mif.core_stall) stall_cycles++;
    step();
    tests++;
    if ({mif.bus_req, mif.bus_we, mif.bus_size, mif.core_done} !== 5'b10110 || mif.bus_addr !== 64'h2008) begin
      fails++;
      $display("FAIL load_busreq: ctrl %b addr %h want 10110 addr 2008",
               {mif.bus_req, mif.bus_we, mif.bus_size, mif.core_done}, mif.bus_addr);
    end
    if (mif.core_stall) stall_cycles++;
    mif.bus_ack = 1'b1; mif.bus_err = 1'b0; mif.bus_rdata = 64'hDEADBEEF_00000001;
    step();
    mif.bus_ack = 1'b0;
    tests++;
    if ({mif.bus_req, mif.core_done, mif.dma_done, mif.rsp_err} !== 4'b0100 || mif.rsp_rdata !== 64'hDEADBEEF_00000001) begin
      fails++;
      $display("FAIL load_done: ctrl %b rdata %h want 0100 rdata deadbeef00000001",
               {mif.bus_req, mif.core_done, mif.dma_done, mif.rsp_err}, mif.rsp_rdata);
    end
    if (mif.core_stall) stall_cycles++;
    mif.core_req = 1'b0;
    step();
    tests++;
    if (mif.core_done !== 1'b0) begin
      fails++;
      $display("FAIL load_pulse: core_done %b want 0", mif.core_done);
    end
    tests++;
    if (stall_cycles != 2) begin
      fails++;
      $display("FAIL load_stall: stall cycles %0d want 2", stall_cycles);
    end
  endtask

  task automatic test_round_robin();
    logic exp_dma;
    do_reset();
    mif.core_req = 1'b1; mif.core_we = 1'b0; mif.core_addr = 64'h1000; mif.core_size = 2'd3;
    mif.dma_req  = 1'b1; mif.dma_we  = 1'b1; mif.dma_addr  = 64'h3000; mif.dma_size  = 2'd3;
    mif.dma_wdata = 64'h0123_4567_89AB_CDEF;
    for (int r = 0; r < 3; r++) begin
      exp_dma = (r == 1);
      step();
      tests++;
      if (mif.bus_req !== 1'b1 || mif.bus_addr !== (exp_dma ? 64'h3000 : 64'h1000)) begin
        fails++;
        $display("FAIL rr_grant round %0d: req %b addr %h want req 1 addr %h",
                 r, mif.bus_req, mif.bus_addr, exp_dma ? 64'h3000 : 64'h1000);
      end
      mif.bus_ack = 1'b1; mif.bus_err = 1'b0; mif.bus_rdata = 64'hA5A5_0000_0000_0000 + 64'(r);
      step();
      mif.bus_ack = 1'b0;
      tests++;
      if ({mif.bus_req, mif.core_done, mif.dma_done} !== {1'b0, ~exp_dma, exp_dma} ||
          mif.rsp_rdata !== (exp_dma ? 64'd0 : 64'hA5A5_0000_0000_0000 + 64'(r))) begin
        fails++;
        $display("FAIL rr_done round %0d: ctrl %b rdata %h want %b", r,
                 {mif.bus_req, mif.core_done, mif.dma_done}, mif.rsp_rdata, {1'b0, ~exp_dma, exp_dma});
      end
      if (exp_dma) mif.dma_req = 1'b0; else mif.core_req = 1'b0;
      step();
      tests++;
      if ({mif.bus_req, mif.core_done, mif.dma_done} !== 3'b000) begin
        fails++;
        $display("FAIL rr_gap round %0d: ctrl %b want 000", r, {mif.bus_req, mif.core_done, mif.dma_done});
      end
      if (exp_dma) mif.dma_req = 1'b1; else mif.core_req = 1'b1;
    end
    idle_inputs();
    step();
  endtask

  task automatic test_misaligned();
    idle_inputs();
    step();
    mif.core_req = 1'b1; mif.core_we = 1'b1; mif.core_addr = 64'h2003; mif.core_size = 2'd2;
    mif.core_wdata = 64'hFFFF_FFFF;
    step();
    tests++;
    if ({mif.bus_req, mif.core_done, mif.dma_done, mif.rsp_err} !== 4'b0101 || mif.rsp_rdata !== 64'd0) begin
      fails++;
      $display("FAIL misaligned: ctrl %b rdata %h want 0101 rdata 0",
               {mif.bus_req, mif.core_done, mif.dma_done, mif.rsp_err}, mif.rsp_rdata);
    end
    mif.core_req = 1'b0;
    step();
    tests++;
    if ({mif.bus_req, mif.core_done} !== 2'b00) begin
      fails++;
      $display("FAIL misaligned_after: ctrl %b want 00", {mif.bus_req, mif.core_done});
    end
  endtask

  task automatic test_flush();
    idle_inputs();
    step();
    mif.core_req = 1'b1; mif.core_we = 1'b0; mif.core_addr = 64'h4010; mif.core_size = 2'd3;
    step();
    mif.flush = 1'b1;
    mif.core_req = 1'b0;
    step();
    mif.flush = 1'b0;
    step();
    step();
    tests++;
    if (mif.bus_req !== 1'b1 || mif.bus_addr !== 64'h4010) begin
      fails++;
      $display("FAIL flush_hold: req %b addr %h want req 1 addr 4010", mif.bus_req, mif.bus_addr);
    end
    mif.bus_ack = 1'b1; mif.bus_rdata = 64'h1111;
    step();
    mif.bus_ack = 1'b0;
    tests++;
    if ({mif.bus_req, mif.core_done, mif.dma_done} !== 3'b000) begin
      fails++;
      $display("FAIL flush_resp: ctrl %b want 000", {mif.bus_req, mif.core_done, mif.dma_done});
    end
    step();
    mif.dma_req = 1'b1; mif.dma_we = 1'b0; mif.dma_addr = 64'h7000; mif.dma_size = 2'd1;
    step();
    tests++;
    if (mif.bus_req !== 1'b1 || mif.bus_addr !== 64'h7000) begin
      fails++;
      $display("FAIL flush_idle: req %b addr %h want req 1 addr 7000", mif.bus_req, mif.bus_addr);
    end
    mif.bus_ack = 1'b1; mif.bus_rdata = 64'h2222;
    step();
    mif.bus_ack = 1'b0;
    mif.dma_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_busy();
    idle_inputs();
    step();
    mif.core_req = 1'b1; mif.core_we = 1'b1; mif.core_addr = 64'h5000; mif.core_size = 2'd2;
    mif.core_wdata = 64'h55AA;
    step();
    #1 reset = 1'b1;
    #1;
    tests++;
    if ({mif.bus_req, mif.bus_we, mif.bus_size, mif.core_done, mif.dma_done, mif.rsp_err} !== 7'b0 ||
        {mif.bus_addr, mif.bus_wdata, mif.rsp_rdata} !== 192'd0) begin
      fails++;
      $display("FAIL reset_busy: ctrl %b addr %h wdata %h want all zero",
               {mif.bus_req, mif.bus_we, mif.bus_size, mif.core_done, mif.dma_done, mif.rsp_err},
               mif.bus_addr, mif.bus_wdata);
    end
    #1 reset = 1'b0;
    step();
    tests++;
    if ({mif.bus_req, mif.bus_we, mif.core_done} !== 3'b110 || mif.bus_addr !== 64'h5000) begin
      fails++;
      $display("FAIL reset_regrant: ctrl %b addr %h want 110 addr 5000",
               {mif.bus_req, mif.bus_we, mif.core_done}, mif.bus_addr);
    end
    mif.bus_ack = 1'b1; mif.bus_rdata = 64'h9999;
    step();
    mif.bus_ack = 1'b0;
    tests++;
    if ({mif.core_done, mif.rsp_err} !== 2'b10 || mif.rsp_rdata !== 64'd0) begin
      fails++;
      $display("FAIL reset_regrant_done: ctrl %b rdata %h want 10 rdata 0", {mif.core_done, mif.rsp_err}, mif.rsp_rdata);
    end
    mif.core_req = 1'b0;
    step();
  endtask

`ifdef MMIO_TIMEOUT_EN
  task automatic test_timeout();
    int held = 0;
    idle_inputs();
    step();
    mif.dma_req = 1'b1; mif.dma_we = 1'b0; mif.dma_addr = 64'h6000; mif.dma_size = 2'd3;
    step();
    for (int i = 0; i < 20 && mif.bus_req; i++) begin
      held++;
      step();
    end
    tests++;
    if (held != int'(TB_TIMEOUT)) begin
      fails++;
      $display("FAIL timeout_len: bus_req held %0d want %0d", held, TB_TIMEOUT);
    end
    tests++;
    if ({mif.dma_done, mif.core_done, mif.rsp_err} !== 3'b101 || mif.rsp_rdata !== 64'd0) begin
      fails++;
      $display("FAIL timeout_resp: ctrl %b rdata %h want 101 rdata 0",
               {mif.dma_done, mif.core_done, mif.rsp_err}, mif.rsp_rdata);
    end
    mif.dma_req = 1'b0;
    step();
  endtask
`endif

  // Transaction-level model: round-robin winner, alignment by modulo, flush kills the core pulse.
  task automatic test_random();
    logic        last_g, w_dma, mis, sup, early, e_we, e_err, exp_core;
    logic [63:0] e_addr, e_wdata, rd;
    logic [1:0]  e_size;
    int          delay;
    do_reset();
    last_g = 1'b1;
    for (int t = 0; t < 80; t++) begin
      if (!mif.core_req && $urandom_range(0, 2) != 0) begin
        mif.core_req = 1'b1; mif.core_we = 1'($urandom); mif.core_size = 2'($urandom);
        mif.core_addr = rand_addr(mif.core_size); mif.core_wdata = {$urandom, $urandom};
      end
      if (!mif.dma_req && $urandom_range(0, 2) != 0) begin
        mif.dma_req = 1'b1; mif.dma_we = 1'($urandom); mif.dma_size = 2'($urandom);
        mif.dma_addr = rand_addr(mif.dma_size); mif.dma_wdata = {$urandom, $urandom};
      end
      if (!mif.core_req && !mif.dma_req) begin
        mif.bus_ack = 1'($urandom); mif.bus_rdata = {$urandom, $urandom};
        step();
        mif.bus_ack = 1'b0;
        tests++;
        if ({mif.bus_req, mif.core_done, mif.dma_done} !== 3'b000) begin
          fails++;
          $display("FAIL rnd_idle t%0d: ctrl %b want 000", t, {mif.bus_req, mif.core_done, mif.dma_done});
        end
        continue;
      end
      w_dma   = mif.dma_req && (!mif.core_req || !last_g);
      last_g  = w_dma;
      e_we    = w_dma ? mif.dma_we    : mif.core_we;
      e_addr  = w_dma ? mif.dma_addr  : mif.core_addr;
      e_wdata = w_dma ? mif.dma_wdata : mif.core_wdata;
      e_size  = w_dma ? mif.dma_size  : mif.core_size;
      mis     = (e_addr % (64'd1 << e_size)) != 64'd0;
      sup     = 1'b0;
      early   = ($urandom_range(0, 3) == 0);
      mif.flush = ($urandom_range(0, 3) == 0);
      step();
      if (!mis) begin
        if (early) begin
          if (w_dma) mif.dma_req = 1'b0; else mif.core_req = 1'b0;
        end
        delay = $urandom_range(0, 3);
        for (int k = 0; k <= delay; k++) begin
          mif.flush = ($urandom_range(0, 3) == 0);
          if (mif.flush && !w_dma) sup = 1'b1;
          tests++;
          if ({mif.bus_req, mif.bus_we, mif.bus_size, mif.core_done, mif.dma_done} !== {1'b1, e_we, e_size, 2'b00} ||
              mif.bus_addr !== e_addr || mif.bus_wdata !== e_wdata) begin
            fails++;
            $display("FAIL rnd_bus t%0d: ctrl %b addr %h wdata %h want %b addr %h wdata %h", t,
                     {mif.bus_req, mif.bus_we, mif.bus_size, mif.core_done, mif.dma_done}, mif.bus_addr, mif.bus_wdata,
                     {1'b1, e_we, e_size, 2'b00}, e_addr, e_wdata);
          end
          if (k == delay) begin
            e_err = 1'($urandom);
            rd    = {$urandom, $urandom};
            mif.bus_ack = 1'b1; mif.bus_err = e_err; mif.bus_rdata = rd;
          end
          step();
        end
        mif.bus_ack = 1'b0;
        if (e_we) rd = 64'd0;
      end else begin
        e_err = 1'b1;
        rd    = 64'd0;
      end
      mif.flush = ($urandom_range(0, 3) == 0);
      if (mif.flush && !w_dma) sup = 1'b1;
      exp_core = !w_dma && !sup;
      #1;
      tests++;
      if ({mif.bus_req, mif.core_done, mif.dma_done, mif.rsp_err} !== {1'b0, exp_core, w_dma, e_err}) begin
        fails++;
        $display("FAIL rnd_done t%0d: ctrl %b want %b", t,
                 {mif.bus_req, mif.core_done, mif.dma_done, mif.rsp_err}, {1'b0, exp_core, w_dma, e_err});
      end
      tests++;
      if (mif.rsp_rdata !== rd) begin
        fails++;
        $display("FAIL rnd_rdata t%0d: got %h want %h", t, mif.rsp_rdata, rd);
      end
      if (w_dma) mif.dma_req = 1'b0; else mif.core_req = 1'b0;
      mif.flush = 1'b0;
      step();
      tests++;
      if ({mif.bus_req, mif.core_done, mif.dma_done} !== 3'b000) begin
        fails++;
        $display("FAIL rnd_resp_len t%0d: ctrl %b want 000", t, {mif.bus_req, mif.core_done, mif.dma_done});
      end
    end
    idle_inputs();
    step();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_core_load();
    test_round_robin();
    test_misaligned();
    test_flush();
    test_reset_mid_busy();
`ifdef MMIO_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/mmio_arbiter.md
MMIO_ARBITER -- requirements
Module: mmio_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the bus-cycle limit for one transaction (8-bit counter, range 1..255).
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 core_req / core_we  input  1/1  MEM-stage MMIO request and write flag; held until core_done.
REQ-005 core_addr / core_wdata  input  64/64  MEM-stage byte address and store data.
REQ-006 core_size  input  2  access size: 0 byte, 1 half, 2 word, 3 dword.
REQ-007 flush  input  1  pipeline flush; drops the core response.
REQ-008 dma_req / dma_we / dma_addr / dma_wdata / dma_size  input  1/1/64/64/2  second requester, same semantics as the core request.
REQ-009 core_done / dma_done  output  1/1  one-cycle completion pulse per requester.
REQ-010 core_stall  output  1  combinational: core_req & ~core_done.
REQ-011 rsp_rdata / rsp_err  output  64/1  response data and error, valid only while a done pulse is high.
REQ-012 bus_req / bus_we / bus_addr / bus_wdata / bus_size  output  1/1/64/64/2  registered peripheral bus request.
REQ-013 bus_ack / bus_err / bus_rdata  input  1/1/64  peripheral completion, error and read data.

Function
REQ-014 FSM states: IDLE, BUSY, RESP, with a 1-bit last_grant register (0 core, 1 dma).
REQ-015 In IDLE with one request pending, that requester wins; with both pending, the requester not equal to last_grant wins (round-robin).
REQ-016 On a win with an aligned address, the arbiter latches the winner's fields to the bus_* outputs, sets bus_req=1, updates last_grant, clears the timeout counter and goes to BUSY on the next edge.
REQ-017 A misaligned address (addr mod 2^size != 0) goes straight to RESP with rsp_err=1, rsp_rdata=0 and no bus_req.
REQ-018 In BUSY, bus_req and all bus_* fields stay constant until bus_ack.
REQ-019 In BUSY on bus_ack, bus_req drops on the next edge, bus_rdata (0 for writes) and bus_err are registered into rsp_*, and the FSM goes to RESP.
REQ-020 In RESP, exactly one cycle: the owner's done pulses, then the FSM returns to IDLE; arbitration resumes the cycle after RESP.
REQ-021 Minimum latency: request seen in cycle N, bus_req in N+1, ack in N+1 gives the done pulse in N+2.
REQ-022 flush asserted in BUSY or RESP while the core owns the transaction: the bus transaction still completes, but core_done is suppressed.
REQ-023 flush has no effect on DMA transactions or on arbitration.
REQ-024 A requester that drops its req before done is ignored; the transaction completes on the bus and the done pulse is still issued.
REQ-025 Simultaneous bus_ack and timeout expiry: bus_ack wins, and rsp_err equals bus_err.
REQ-026 bus_ack while not in BUSY is ignored.

Reset
REQ-027 On reset: FSM=IDLE, last_grant=1 (core wins the first tie), counter=0.
REQ-028 On reset: bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_size=0, rsp_rdata=0, rsp_err=0, core_done=0, dma_done=0.
REQ-029 Reset asserted mid-BUSY abandons the transaction immediately; no done pulse is generated.

Configuration
REQ-030 Macro MMIO_TIMEOUT_EN defined: the counter increments each BUSY cycle without bus_ack.
REQ-031 With MMIO_TIMEOUT_EN, when the counter reaches TIMEOUT_CYCLES the arbiter drops bus_req, sets rsp_err=1 and rsp_rdata=0, and goes to RESP.
REQ-032 Macro undefined: no counter exists, BUSY waits indefinitely for bus_ack, and rsp_err comes only from bus_err or misalignment.

Verification
REQ-033 Core load, addr 0x2008, size 3; bus_ack one cycle after bus_req with rdata 0xDEADBEEF_00000001 -> core_done 2 cycles after core_req, rsp_rdata matches, core_stall high for exactly 2 cycles.
REQ-034 Core and dma requests in the same cycle for 3 back-to-back rounds -> grants core, dma, core; each bus transaction separated by the RESP cycle.
REQ-035 Core store, addr 0x2003, size 2 -> no bus_req, core_done with rsp_err=1 in the next cycle.
REQ-036 Core load in BUSY, flush pulsed, bus_ack 3 cycles later -> bus_req drops, no core_done, FSM back in IDLE.
REQ-037 MMIO_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, no bus_ack -> bus_req held 4 cycles, then dma_done with rsp_err=1 and rsp_rdata=0.
REQ-038 Reset asserted during BUSY -> all outputs 0 immediately; the next core request is granted normally.
